// File: rtl/tlb_miss_queue_if.sv
// ============================================================================
// Module : tlb_miss_queue_if
// Brief  : Miss-report, walker-handshake and status bundle for tlb_miss_queue.
//          Optional stat_* members exist when TLB_MISS_QUEUE_STATS_EN is defined.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface tlb_miss_queue_if #(
  parameter int DEPTH = 4
) ();
  localparam int c_CW = $clog2(DEPTH) + 1;

  logic            flush;
  logic            miss_v;
  logic [31:0]     miss_adr;
  logic [15:0]     miss_asid;
  logic [7:0]      miss_id;
  logic            ptw_req_v;
  logic            ptw_req_rdy;
  logic [31:0]     ptw_req_adr;
  logic [15:0]     ptw_req_asid;
  logic [7:0]      ptw_req_id;
  logic            ptw_done;
  logic            full;
  logic            overflow;
  logic [c_CW-1:0] count;
`ifdef TLB_MISS_QUEUE_STATS_EN
  logic [15:0]     stat_enq;
  logic [15:0]     stat_dup;
  logic [15:0]     stat_ovf;
`endif

  modport master (
    output flush, miss_v, miss_adr, miss_asid, miss_id, ptw_req_rdy, ptw_done,
    input  ptw_req_v, ptw_req_adr, ptw_req_asid, ptw_req_id, full, overflow, count
`ifdef TLB_MISS_QUEUE_STATS_EN
    , input stat_enq, stat_dup, stat_ovf
`endif
  );

  modport slave (
    input  flush, miss_v, miss_adr, miss_asid, miss_id, ptw_req_rdy, ptw_done,
    output ptw_req_v, ptw_req_adr, ptw_req_asid, ptw_req_id, full, overflow, count
`ifdef TLB_MISS_QUEUE_STATS_EN
    , output stat_enq, stat_dup, stat_ovf
`endif
  );
endinterface

`default_nettype wire

// File: rtl/tlb_miss_queue.sv
// ============================================================================
// Module : tlb_miss_queue
// Brief  : Deduplicating in-order TLB miss buffer feeding a single-outstanding
//          page-table walker. TLB_MISS_QUEUE_STATS_EN adds saturating counters.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tlb_miss_queue #(
  parameter int DEPTH        = 4,
  parameter int LOG_PAGESIZE = 13
) (
  input  logic           clk,
  input  logic           rst,
  tlb_miss_queue_if.slave bus
);
  localparam int c_PW = $clog2(DEPTH);
  localparam int c_CW = $clog2(DEPTH) + 1;
  localparam int c_VW = 32 - LOG_PAGESIZE;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t            r_state;
  logic [DEPTH-1:0]  r_valid;
  logic [c_VW-1:0]   r_vpn  [DEPTH];
  logic [15:0]       r_asid [DEPTH];
  logic [31:0]       r_adr  [DEPTH];
  logic [7:0]        r_id   [DEPTH];
  logic [c_PW-1:0]   r_head;
  logic [c_PW-1:0]   r_tail;
  logic [c_CW-1:0]   r_count;
  logic              r_req_v;
  logic [31:0]       r_req_adr;
  logic [15:0]       r_req_asid;
  logic [7:0]        r_req_id;
  logic              r_overflow;

  logic [c_VW-1:0]   w_vpn;
  logic              w_pop;
  logic              w_full;
  logic [DEPTH-1:0]  w_hit;
  logic              w_dup;
  logic              w_new;
  logic              w_enq;
  logic              w_ovf;
  logic [DEPTH-1:0]  w_valid_nxt;
  logic [c_CW-1:0]   w_count_nxt;
  logic [c_PW-1:0]   w_tail_nxt;

  assign w_vpn  = bus.miss_adr[31:LOG_PAGESIZE];
  assign w_pop  = (r_state == S_WAIT) && bus.ptw_done;
  assign w_full = (r_count == c_CW'(DEPTH));

  // The entry retiring this cycle must not mask a fresh miss to the same page.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
      assign w_hit[gi] = r_valid[gi]
                       && (r_vpn[gi] == w_vpn)
                       && (r_asid[gi] == bus.miss_asid)
                       && !(w_pop && (r_head == c_PW'(gi)));
    end
  endgenerate

  assign w_dup = |w_hit;
  assign w_new = bus.miss_v && !bus.flush && !w_dup;
  assign w_enq = w_new && !w_full;
  assign w_ovf = w_new && w_full;

  always_comb begin
    w_valid_nxt = r_valid;
    w_count_nxt = r_count;
    w_tail_nxt  = r_tail;
    if (bus.flush) begin
      w_valid_nxt = '0;
      w_count_nxt = '0;
      w_tail_nxt  = r_head;
      if (r_state != S_IDLE) begin
        // Head survives unless it retires now; either way the tail lands just past it.
        w_tail_nxt = r_head + 1'b1;
        if (!w_pop) begin
          w_valid_nxt[r_head] = r_valid[r_head];
          w_count_nxt         = c_CW'(1);
        end
      end
    end else begin
      if (w_pop) begin
        w_valid_nxt[r_head] = 1'b0;
      end
      if (w_enq) begin
        w_valid_nxt[r_tail] = 1'b1;
        w_tail_nxt          = r_tail + 1'b1;
      end
      w_count_nxt = r_count + {{(c_CW-1){1'b0}}, w_enq} - {{(c_CW-1){1'b0}}, w_pop};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid    <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_valid    <= w_valid_nxt;
      r_tail     <= w_tail_nxt;
      r_count    <= w_count_nxt;
      r_overflow <= w_ovf;
      if (w_pop) begin
        r_head <= r_head + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_vpn[r_tail]  <= w_vpn;
      r_asid[r_tail] <= bus.miss_asid;
      r_adr[r_tail]  <= bus.miss_adr;
      r_id[r_tail]   <= bus.miss_id;
    end
  end

  // Request fields are captured on IDLE->REQ so they hold steady until accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_req_v    <= 1'b0;
      r_req_adr  <= '0;
      r_req_asid <= '0;
      r_req_id   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if ((r_count != '0) && !bus.flush) begin
            r_state    <= S_REQ;
            r_req_v    <= 1'b1;
            r_req_adr  <= r_adr[r_head];
            r_req_asid <= r_asid[r_head];
            r_req_id   <= r_id[r_head];
          end
        end
        S_REQ: begin
          if (bus.ptw_req_rdy) begin
            r_state <= S_WAIT;
            r_req_v <= 1'b0;
          end
        end
        S_WAIT: begin
          if (bus.ptw_done) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_req_v <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ptw_req_v    = r_req_v;
  assign bus.ptw_req_adr  = r_req_adr;
  assign bus.ptw_req_asid = r_req_asid;
  assign bus.ptw_req_id   = r_req_id;
  assign bus.full         = w_full;
  assign bus.overflow     = r_overflow;
  assign bus.count        = r_count;

`ifdef TLB_MISS_QUEUE_STATS_EN
  logic [15:0] r_stat_enq;
  logic [15:0] r_stat_dup;
  logic [15:0] r_stat_ovf;
  logic        w_dup_drop;

  assign w_dup_drop = bus.miss_v && !bus.flush && w_dup;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stat_enq <= '0;
      r_stat_dup <= '0;
      r_stat_ovf <= '0;
    end else begin
      if (w_enq && (r_stat_enq != 16'hFFFF)) begin
        r_stat_enq <= r_stat_enq + 16'd1;
      end
      if (w_dup_drop && (r_stat_dup != 16'hFFFF)) begin
        r_stat_dup <= r_stat_dup + 16'd1;
      end
      if (w_ovf && (r_stat_ovf != 16'hFFFF)) begin
        r_stat_ovf <= r_stat_ovf + 16'd1;
      end
    end
  end

  assign bus.stat_enq = r_stat_enq;
  assign bus.stat_dup = r_stat_dup;
  assign bus.stat_ovf = r_stat_ovf;
`endif

endmodule

`default_nettype wire

// File: tb/tb_tlb_miss_queue.sv
// ============================================================================
// Module : tb_tlb_miss_queue
// Brief  : Directed stimulus with a queue-level reference model for tlb_miss_queue.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_tlb_miss_queue;
  localparam int DEPTH = 4;
  localparam int LOGP  = 13;

  typedef struct {
    logic [18:0] vpn;
    logic [15:0] asid;
    logic [31:0] adr;
    logic [7:0]  id;
  } ent_t;

  logic clk;
  logic rst;

  tlb_miss_queue_if #(.DEPTH(DEPTH)) bus ();

  tlb_miss_queue #(.DEPTH(DEPTH), .LOG_PAGESIZE(LOGP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list of pending misses plus the walk phase
  ent_t        mq[$];
  int          mph;
  logic [31:0] m_adr;
  logic [15:0] m_asid;
  logic [7:0]  m_id;
  logic        m_ovf;
  int          m_enq, m_dup, m_ovc;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      mph = 0; m_adr = 0; m_asid = 0; m_id = 0; m_ovf = 0;
      m_enq = 0; m_dup = 0; m_ovc = 0;
    end else begin
      bit pop, dup, nw, fullp;
      int ph_n;
      ent_t e, keep;
      pop = (mph == 2) && bus.ptw_done;
      dup = 0;
      for (int k = 0; k < mq.size(); k++)
        if (!(pop && k == 0) && mq[k].vpn == bus.miss_adr[31:LOGP] && mq[k].asid == bus.miss_asid)
          dup = 1;
      nw    = bus.miss_v && !bus.flush && !dup;
      fullp = (mq.size() == DEPTH);
      m_ovf = nw && fullp;
      if (nw && !fullp) m_enq++;
      if (nw && fullp) m_ovc++;
      if (bus.miss_v && !bus.flush && dup) m_dup++;
      ph_n = mph;
      if (mph == 0 && mq.size() != 0 && !bus.flush) begin
        ph_n = 1; m_adr = mq[0].adr; m_asid = mq[0].asid; m_id = mq[0].id;
      end else if (mph == 1 && bus.ptw_req_rdy) ph_n = 2;
      else if (mph == 2 && bus.ptw_done) ph_n = 0;
      if (pop) void'(mq.pop_front());
      if (bus.flush) begin
        if (mph != 0 && mq.size() != 0 && !pop) begin
          keep = mq[0]; mq.delete(); mq.push_back(keep);
        end else mq.delete();
      end
      if (nw && !fullp) begin
        e.vpn = bus.miss_adr[31:LOGP]; e.asid = bus.miss_asid;
        e.adr = bus.miss_adr; e.id = bus.miss_id;
        mq.push_back(e);
      end
      mph = ph_n;
    end
  end

  always @(negedge clk) begin
    chk("count", 32'(bus.count), 32'(mq.size()));
    chk("full", 32'(bus.full), 32'(mq.size() == DEPTH));
    chk("overflow", 32'(bus.overflow), 32'(m_ovf));
    chk("req_v", 32'(bus.ptw_req_v), 32'(mph == 1));
    if (mph == 1) begin
      chk("req_adr", bus.ptw_req_adr, m_adr);
      chk("req_asid", 32'(bus.ptw_req_asid), 32'(m_asid));
      chk("req_id", 32'(bus.ptw_req_id), 32'(m_id));
    end
`ifdef TLB_MISS_QUEUE_STATS_EN
    chk("stat_enq", 32'(bus.stat_enq), 32'(m_enq));
    chk("stat_dup", 32'(bus.stat_dup), 32'(m_dup));
    chk("stat_ovf", 32'(bus.stat_ovf), 32'(m_ovc));
`endif
  end

  logic [31:0] got[$];
  always @(posedge clk)
    if (rst && bus.ptw_req_v && bus.ptw_req_rdy) got.push_back(bus.ptw_req_adr);

  task automatic step();
    @(negedge clk);
  endtask

  task automatic miss(input logic [31:0] a, input logic [15:0] s, input logic [7:0] i);
    step();
    bus.miss_v = 1'b1; bus.miss_adr = a; bus.miss_asid = s; bus.miss_id = i;
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    bus.miss_v = 1'b0; bus.ptw_req_rdy = 1'b1; bus.ptw_done = 1'b1;
    for (int k = 0; k < 60; k++) begin
      step();
      if (bus.count == 0 && !bus.ptw_req_v) begin
        ok = 1;
        break;
      end
    end
    bus.ptw_req_rdy = 1'b0; bus.ptw_done = 1'b0;
    chk("drain_timeout", 32'(ok), 32'd1);
    step();
  endtask

  initial begin
    rst = 1'b1;
    bus.flush = 0; bus.miss_v = 0; bus.miss_adr = 0; bus.miss_asid = 0; bus.miss_id = 0;
    bus.ptw_req_rdy = 0; bus.ptw_done = 0;
    #3 rst = 1'b0;
    step();
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_req_v", 32'(bus.ptw_req_v), 32'd0);
    chk("rst_full", 32'(bus.full), 32'd0);
    rst = 1'b1;
    step();

    // 1: single miss, request two cycles later, done retires it
    miss(32'h0000_4010, 16'd5, 8'd3);
    bus.ptw_req_rdy = 1'b1;
    step(); bus.miss_v = 1'b0;
    chk("t1_count1", 32'(bus.count), 32'd1);
    step();
    chk("t1_req_v", 32'(bus.ptw_req_v), 32'd1);
    chk("t1_adr", bus.ptw_req_adr, 32'h0000_4010);
    chk("t1_asid", 32'(bus.ptw_req_asid), 32'd5);
    chk("t1_id", 32'(bus.ptw_req_id), 32'd3);
    step(); bus.ptw_req_rdy = 1'b0; bus.ptw_done = 1'b1;
    step(); bus.ptw_done = 1'b0;
    chk("t1_count0", 32'(bus.count), 32'd0);

    // 2: level miss held 10 cycles on one page -> one entry, 9 duplicates
    miss(32'h0000_4010, 16'd5, 8'd1);
    repeat (4) step();
    step(); bus.miss_adr = 32'h0000_5FF0;
    repeat (4) step();
    step(); bus.miss_v = 1'b0;
    chk("t2_count", 32'(bus.count), 32'd1);
    chk("t2_adr", bus.ptw_req_adr, 32'h0000_4010);
`ifdef TLB_MISS_QUEUE_STATS_EN
    chk("t2_stat_dup", 32'(bus.stat_dup), 32'd9);
`endif
    drain();

    // 3: five distinct pages into four entries, then FIFO issue order
    got.delete();
    for (int i = 0; i < 5; i++) miss(((i + 1) << 13) | 32'h100, 16'd7, 8'(i));
    step(); bus.miss_v = 1'b0;
    chk("t3_count", 32'(bus.count), 32'd4);
    chk("t3_full", 32'(bus.full), 32'd1);
    chk("t3_ovf", 32'(bus.overflow), 32'd1);
    step();
    chk("t3_ovf_pulse", 32'(bus.overflow), 32'd0);
    drain();
    chk("t3_nreq", 32'(got.size()), 32'd4);
    for (int k = 0; k < 4 && k < got.size(); k++) chk("t3_order", got[k], ((k + 1) << 13) | 32'h100);

    // 4: flush in WAIT keeps only the in-flight head
    miss(32'h0002_0000, 16'd1, 8'd0);
    miss(32'h0002_2000, 16'd1, 8'd1);
    miss(32'h0002_4000, 16'd1, 8'd2);
    step(); bus.miss_v = 1'b0; bus.ptw_req_rdy = 1'b1;
    step(); bus.ptw_req_rdy = 1'b0; bus.flush = 1'b1;
    step(); bus.flush = 1'b0;
    chk("t4_count1", 32'(bus.count), 32'd1);
    bus.ptw_done = 1'b1;
    step(); bus.ptw_done = 1'b0;
    chk("t4_count0", 32'(bus.count), 32'd0);
    repeat (3) step();
    chk("t4_req_v", 32'(bus.ptw_req_v), 32'd0);

    // 5: re-miss on the retiring page re-enqueues; other asid is distinct
    got.delete();
    miss(32'h0000_4010, 16'd5, 8'd4);
    miss(32'h0000_4020, 16'd6, 8'd5);
    step(); bus.miss_v = 1'b0; bus.ptw_req_rdy = 1'b1;
    chk("t5_count2", 32'(bus.count), 32'd2);
    step(); bus.ptw_req_rdy = 1'b0; bus.ptw_done = 1'b1;
    bus.miss_v = 1'b1; bus.miss_adr = 32'h0000_4010; bus.miss_asid = 16'd5; bus.miss_id = 8'd9;
    step(); bus.ptw_done = 1'b0; bus.miss_v = 1'b0;
    chk("t5_count_same", 32'(bus.count), 32'd2);
    drain();
    chk("t5_nreq", 32'(got.size()), 32'd3);
    if (got.size() == 3) chk("t5_last", got[2], 32'h0000_4010);

    // 6: asynchronous reset mid-walk, late done ignored
    miss(32'h0000_6000, 16'd2, 8'd1);
    miss(32'h0000_8000, 16'd2, 8'd2);
    step(); bus.miss_v = 1'b0; bus.ptw_req_rdy = 1'b1;
    step(); bus.ptw_req_rdy = 1'b0;
    chk("t6_count2", 32'(bus.count), 32'd2);
    #2 rst = 1'b0;
    #1;
    chk("t6_async_count", 32'(bus.count), 32'd0);
    chk("t6_async_req_v", 32'(bus.ptw_req_v), 32'd0);
    chk("t6_async_adr", bus.ptw_req_adr, 32'd0);
    chk("t6_async_full", 32'(bus.full), 32'd0);
`ifdef TLB_MISS_QUEUE_STATS_EN
    chk("t6_async_stat", 32'(bus.stat_enq), 32'd0);
`endif
    step(); rst = 1'b1;
    step(); bus.ptw_done = 1'b1;
    step(); bus.ptw_done = 1'b0;
    chk("t6_count0", 32'(bus.count), 32'd0);
    step();
    chk("t6_req_v", 32'(bus.ptw_req_v), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

`default_nettype wire
